boot_loader_ctrl: RTL and testbench

//  Boot sequencer for the RV32I pipelined core.
//  - Holds the core in reset while it loads a program from a byte stream into instruction memory.
//  - Drives the Fetch stage's memory write port (WE_mem / WD_mem plus a write address).
//  - Releases the core once the programmed word count has been written.
//  - Stream format: 2-byte little-endian word count N, then N little-endian 32-bit words.

---
 rtl/boot_loader_ctrl.sv | 148 ++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module      : boot_loader_ctrl
// Description : Holds the RV32I core in reset while a length-prefixed byte
//               stream is written into instruction memory, then releases it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module boot_loader_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              core_reset,
  output logic              WE_mem,
  output logic [31:0]       WD_mem,
  output logic [ADDR_W-1:0] WA_mem,
  output logic              done,
  output logic              err_overflow
);

  localparam int          IDX_W       = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] c_maxWords  = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_DATA    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_RUN     = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_wordIdx;
  logic [1:0]       r_byteIdx;
  logic [15:0]      r_n;
  logic [23:0]      r_partial;

  logic              w_accept;
  logic [15:0]       w_nFull;
  logic [ADDR_W-1:0] w_wa;
  logic              w_lastWord;

  always_comb begin
    byte_ready = 1'b0;
    if (!Reset) begin
      byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
    end
  end

  assign w_accept   = byte_valid && byte_ready;
  assign w_nFull    = {byte_data, r_n[7:0]};
  assign w_wa       = ADDR_W'({r_wordIdx, 2'b00});
  assign w_lastWord = ((17'(r_wordIdx) + 17'd1) == {1'b0, r_n});

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= S_HDR0;
      r_wordIdx    <= '0;
      r_byteIdx    <= '0;
      r_n          <= '0;
      r_partial    <= '0;
      core_reset   <= 1'b1;
      WE_mem       <= 1'b0;
      WD_mem       <= '0;
      WA_mem       <= '0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      WE_mem <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_accept) begin
            r_n[7:0] <= byte_data;
            r_state  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_accept) begin
            r_n[15:8] <= byte_data;
            if (w_nFull == 16'd0) begin
              r_state <= S_RELEASE;
            end else if (w_nFull > c_maxWords) begin
              r_state      <= S_ERROR;
              err_overflow <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            // Bytes shift in from the top so the first one lands in bits [7:0].
            if (r_byteIdx == 2'd3) begin
              WE_mem    <= 1'b1;
              WD_mem    <= {byte_data, r_partial};
              WA_mem    <= w_wa;
              r_byteIdx <= 2'd0;
              r_state   <= S_WRITE;
            end else begin
              r_partial <= {byte_data, r_partial[23:8]};
              r_byteIdx <= r_byteIdx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          r_wordIdx <= r_wordIdx + 1'b1;
          r_state   <= w_lastWord ? S_RELEASE : S_DATA;
        end
        S_RELEASE: begin
          core_reset <= 1'b0;
          done       <= 1'b1;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (load_req) begin
            r_state    <= S_HDR0;
            core_reset <= 1'b1;
            r_wordIdx  <= '0;
            r_byteIdx  <= '0;
            r_n        <= '0;
          end
        end
        S_ERROR: begin
          if (load_req) begin
            r_state      <= S_HDR0;
            err_overflow <= 1'b0;
            r_wordIdx    <= '0;
            r_byteIdx    <= '0;
            r_n          <= '0;
          end
        end
        default: r_state <= S_HDR0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_boot_loader_ctrl
// Description : Directed vector table plus a full-size load with idle gaps.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_boot_loader_ctrl;

  logic        clk;
  logic        Reset;
  logic        load_req;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        core_reset;
  logic        WE_mem;
  logic [31:0] WD_mem;
  logic [9:0]  WA_mem;
  logic        done;
  logic        err_overflow;

  boot_loader_ctrl #(.ADDR_W(10), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .core_reset   (core_reset),
    .WE_mem       (WE_mem),
    .WD_mem       (WD_mem),
    .WA_mem       (WA_mem),
    .done         (done),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        ld;
    logic        eWe;
    logic [9:0]  eWa;
    logic [31:0] eWd;
    logic        eRdy;
    logic        eCr;
    logic        eDone;
    logic        eErr;
  } vec_t;

  vec_t rows[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic ld,
                     input logic we, input logic [9:0] wa, input logic [31:0] wd,
                     input logic rdy, input logic cr, input logic dn, input logic er);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.ld = ld;
    r.eWe = we; r.eWa = wa; r.eWd = wd; r.eRdy = rdy; r.eCr = cr; r.eDone = dn; r.eErr = er;
    rows.push_back(r);
  endtask

  // Shorthand for a row with no memory write expected.
  task automatic addN(input logic rst, input logic v, input logic [7:0] d, input logic ld,
                      input logic rdy, input logic cr, input logic dn, input logic er);
    add(rst, v, d, ld, 1'b0, 10'h0, 32'h0, rdy, cr, dn, er);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wordVal(input int k);
    return 32'h89AB_CDEF + 32'h0100_0193 * k;
  endfunction

  initial begin
    logic [7:0]  stream[$];
    logic [31:0] w;
    int          byteNo;
    int          cyc;
    int          weCnt;
    logic        acc;
    logic        expWe;

    Reset = 1'b1; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Two-word load
    addN(1, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(1, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 1, 8'h02, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h13, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h05, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h50, 0, 1, 1, 0, 0);
    add (0, 1, 8'h00, 0, 1, 10'h000, 32'h0050_0513, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h93, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h05, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hA0, 0, 1, 1, 0, 0);
    add (0, 1, 8'h00, 0, 1, 10'h004, 32'h00A0_0593, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 1, 0, 0, 1, 0);
    addN(0, 0, 8'h00, 0, 0, 0, 0, 0);
    // Empty program
    addN(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 0, 1, 0);
    // Overflow header N=257, recovery by load_req
    addN(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addN(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addN(0, 1, 8'h01, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h01, 0, 0, 1, 0, 1);
    addN(0, 1, 8'h55, 0, 0, 1, 0, 1);
    addN(0, 0, 8'h00, 1, 1, 1, 0, 0);
    // Reset mid-word, then a clean one-word load
    addN(0, 1, 8'h01, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hEF, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hBE, 0, 1, 1, 0, 0);
    addN(1, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 1, 8'h01, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hEF, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hBE, 0, 1, 1, 0, 0);
    addN(0, 1, 8'hAD, 0, 1, 1, 0, 0);
    add (0, 1, 8'hDE, 0, 1, 10'h000, 32'hDEAD_BEEF, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 0, 1, 0);
    // Reload from RUN
    addN(0, 0, 8'h00, 1, 1, 1, 0, 0);
    addN(0, 1, 8'h01, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h13, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    addN(0, 1, 8'h00, 0, 1, 1, 0, 0);
    add (0, 1, 8'h00, 0, 1, 10'h000, 32'h0000_0013, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 1, 0, 0);
    addN(0, 0, 8'h00, 0, 0, 0, 1, 0);

    for (int i = 0; i < rows.size(); i++) begin
      Reset      = rows[i].rst;
      byte_valid = rows[i].v;
      byte_data  = rows[i].d;
      load_req   = rows[i].ld;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d WE_mem", i), 32'(WE_mem), 32'(rows[i].eWe));
      chk($sformatf("row%0d byte_ready", i), 32'(byte_ready), 32'(rows[i].eRdy));
      chk($sformatf("row%0d core_reset", i), 32'(core_reset), 32'(rows[i].eCr));
      chk($sformatf("row%0d done", i), 32'(done), 32'(rows[i].eDone));
      chk($sformatf("row%0d err_overflow", i), 32'(err_overflow), 32'(rows[i].eErr));
      if (rows[i].eWe) begin
        chk($sformatf("row%0d WA_mem", i), 32'(WA_mem), 32'(rows[i].eWa));
        chk($sformatf("row%0d WD_mem", i), WD_mem, rows[i].eWd);
      end
    end

    // Full 256-word load with random idle gaps
    Reset = 1'b0; byte_valid = 1'b0; load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    chk("full reload core_reset", 32'(core_reset), 32'd1);

    stream.push_back(8'h00);
    stream.push_back(8'h01);
    for (int k = 0; k < 256; k++) begin
      w = wordVal(k);
      stream.push_back(w[7:0]);
      stream.push_back(w[15:8]);
      stream.push_back(w[23:16]);
      stream.push_back(w[31:24]);
    end

    byteNo = 0; cyc = 0; weCnt = 0;
    while (byteNo < stream.size() && cyc < 6000) begin
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_data  = stream[byteNo];
      acc        = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      cyc++;
      expWe = acc && (byteNo >= 2) && (((byteNo - 2) % 4) == 3);
      chk($sformatf("full cyc%0d WE_mem", cyc), 32'(WE_mem), 32'(expWe));
      if (expWe && WE_mem) begin
        chk($sformatf("full word%0d WA_mem", weCnt), 32'(WA_mem), 32'(weCnt * 4));
        chk($sformatf("full word%0d WD_mem", weCnt), WD_mem, wordVal(weCnt));
        weCnt++;
      end
      if (acc) byteNo++;
    end
    byte_valid = 1'b0;
    if (cyc >= 6000) chk("full load timeout", 32'(byteNo), 32'(stream.size()));
    chk("full load write count", 32'(weCnt), 32'd256);

    @(posedge clk);
    #1;
    chk("full release core_reset", 32'(core_reset), 32'd1);
    chk("full release done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("full run core_reset", 32'(core_reset), 32'd0);
    chk("full run done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
